// File: rtl/jtframe_arb_pkg.sv
// Shared types and helpers for the per-bank SDRAM arbiter.
//   arb_st_t : ownership FSM states (IDLE, PROG, REQ, DATA)
//   CH_MAX   : largest supported client count
//   idx_w()  : width of a client index for a given client count (at least 1)
//   onehot() : one-hot client vector from a client index
package jtframe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        REQ  = 2'd2,
        DATA = 2'd3
    } arb_st_t;

    localparam int CH_MAX = 8;

    function automatic int idx_w(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

    function automatic logic [CH_MAX-1:0] onehot(input logic [2:0] idx);
        logic [CH_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/jtframe_arb_pick.sv
// Combinational winner selection for the bank arbiter.
// Build option: JTFRAME_ARB_RR_EN
//   defined   : round-robin, search starts at ptr (last owner + 1)
//   undefined : fixed priority, lowest index wins; ptr is ignored
// Ports:
//   req   in  CH   pending requests (rd | wr per client)
//   ptr   in  CHW  round-robin start index
//   valid out 1    at least one request pending
//   win   out CHW  index of the selected client
module jtframe_arb_pick
    import jtframe_arb_pkg::*;
#(
    parameter int CH  = 4,
    parameter int CHW = 2
) (
    input  logic [CH-1:0]  req,
    input  logic [CHW-1:0] ptr,
    output logic           valid,
    output logic [CHW-1:0] win
);

`ifdef JTFRAME_ARB_RR_EN
    // Two passes folded into one loop: the lowest requester at or above the
    // pointer wins; if there is none, wrap around to the lowest requester.
    logic           hi_valid;
    logic [CHW-1:0] hi_win;
    logic [CHW-1:0] lo_win;

    always_comb begin
        valid    = 1'b0;
        hi_valid = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid  = 1'b1;
                lo_win = CHW'(i);
                if (CHW'(i) >= ptr) begin
                    hi_valid = 1'b1;
                    hi_win   = CHW'(i);
                end
            end
        end
        win = hi_valid ? hi_win : lo_win;
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                win   = CHW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/jtframe_bank_arb.sv
// Per-bank SDRAM request arbiter. Merges CH game clients and the ROM download
// (prog) path onto one SDRAM bank port, with an ownership FSM and a response
// watchdog that aborts a transaction whose rdy never arrives.
// Build option: JTFRAME_ARB_RR_EN selects round-robin arbitration; without it
// the lowest client index always wins and the pointer register is not built.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   downloading                    1 = prog path owns the bank
//   ch_addr/rd/wr/din/din_m        packed client requests (client i at [i*W+:W])
//   ch_ack/dst/dok/rdy             one-hot client responses
//   ch_dout                        last read word, shared by all clients
//   prog_addr/we/rd/data/mask      download path request
//   prog_ack/prog_rdy              controller handshake while downloading
//   ba_addr/rd/wr/din/din_m        request to the SDRAM controller
//   ba_ack/dst/dok/rdy, sdram_dout responses from the SDRAM controller
//   err                            sticky watchdog flag
module jtframe_bank_arb
    import jtframe_arb_pkg::*;
#(
    parameter int AW   = 22,
    parameter int DW   = 16,
    parameter int CH   = 4,
    parameter int TOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             downloading,
    input  logic [CH*AW-1:0] ch_addr,
    input  logic [CH-1:0]    ch_rd,
    input  logic [CH-1:0]    ch_wr,
    input  logic [CH*DW-1:0] ch_din,
    input  logic [CH*2-1:0]  ch_din_m,
    output logic [CH-1:0]    ch_ack,
    output logic [CH-1:0]    ch_dst,
    output logic [CH-1:0]    ch_dok,
    output logic [CH-1:0]    ch_rdy,
    output logic [DW-1:0]    ch_dout,
    input  logic [AW-1:0]    prog_addr,
    input  logic             prog_we,
    input  logic             prog_rd,
    input  logic [DW-1:0]    prog_data,
    input  logic [1:0]       prog_mask,
    output logic             prog_ack,
    output logic             prog_rdy,
    output logic [AW-1:0]    ba_addr,
    output logic             ba_rd,
    output logic             ba_wr,
    output logic [DW-1:0]    ba_din,
    output logic [1:0]       ba_din_m,
    input  logic             ba_ack,
    input  logic             ba_dst,
    input  logic             ba_dok,
    input  logic             ba_rdy,
    input  logic [DW-1:0]    sdram_dout,
    output logic             err
);

    localparam int CHW = idx_w(CH);
    localparam int CW  = $clog2(TOUT + 1);

    arb_st_t        state_reg, state_next;
    logic [CHW-1:0] owner_reg, owner_next;
    logic           is_rd_reg, is_rd_next;
    logic [AW-1:0]  addr_reg, addr_next;
    logic [DW-1:0]  din_reg, din_next;
    logic [1:0]     mask_reg, mask_next;
    logic [DW-1:0]  dout_reg;
    logic [CW-1:0]  wd_cnt_reg;
    logic           err_reg;
    logic           prog_busy_reg, prog_busy_next;

    logic           ack_hit, rdy_hit, data_phase, dout_load, timeout, grant;
    logic           dispatch;
    logic [CH-1:0]  owner_oh;
    logic           pick_valid;
    logic [CHW-1:0] pick_idx;
    logic [CHW-1:0] ptr;

    logic [AW-1:0]  addr_arr [CH];
    logic [DW-1:0]  din_arr  [CH];
    logic [1:0]     mask_arr [CH];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            assign addr_arr[gi] = ch_addr[gi*AW +: AW];
            assign din_arr[gi]  = ch_din[gi*DW +: DW];
            assign mask_arr[gi] = ch_din_m[gi*2 +: 2];
            assign ch_ack[gi]   = ack_hit & owner_oh[gi];
            assign ch_rdy[gi]   = rdy_hit & owner_oh[gi];
            assign ch_dst[gi]   = data_phase & ba_dst & owner_oh[gi];
            assign ch_dok[gi]   = data_phase & ba_dok & owner_oh[gi];
        end
    endgenerate

    assign owner_oh = CH'(onehot(3'(owner_reg)));

    jtframe_arb_pick #(
        .CH  (CH),
        .CHW (CHW)
    ) u_pick (
        .req   (ch_rd | ch_wr),
        .ptr   (ptr),
        .valid (pick_valid),
        .win   (pick_idx)
    );

`ifdef JTFRAME_ARB_RR_EN
    logic [CHW-1:0] ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (grant) begin
            ptr_reg <= (pick_idx == CHW'(CH - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    // A prog access is outstanding from its ack until its rdy; the bank is
    // only handed back to the clients once nothing is in flight.
    assign prog_busy_next = (prog_busy_reg | ba_ack) & ~ba_rdy;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        is_rd_next = is_rd_reg;
        addr_next  = addr_reg;
        din_next   = din_reg;
        mask_next  = mask_reg;
        ba_addr    = addr_reg;
        ba_din     = din_reg;
        ba_din_m   = mask_reg;
        ba_rd      = 1'b0;
        ba_wr      = 1'b0;
        prog_ack   = 1'b0;
        prog_rdy   = 1'b0;
        ack_hit    = 1'b0;
        rdy_hit    = 1'b0;
        data_phase = 1'b0;
        dout_load  = 1'b0;
        timeout    = 1'b0;
        grant      = 1'b0;
        dispatch   = 1'b0;

        case (state_reg)
            IDLE: begin
                dispatch = 1'b1;
            end
            PROG: begin
                ba_addr  = prog_addr;
                ba_rd    = prog_rd;
                ba_wr    = prog_we;
                ba_din   = prog_data;
                ba_din_m = prog_mask;
                prog_ack = ba_ack;
                prog_rdy = ba_rdy;
                if (!downloading && !prog_busy_next) begin
                    state_next = IDLE;
                end
            end
            REQ: begin
                // The request is withdrawn in the very cycle it is acked.
                ba_rd = is_rd_reg & ~ba_ack;
                ba_wr = ~is_rd_reg & ~ba_ack;
                if (ba_ack) begin
                    ack_hit = 1'b1;
                    if (ba_rdy) begin
                        rdy_hit    = 1'b1;
                        dout_load  = is_rd_reg;
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                data_phase = 1'b1;
                if (ba_rdy) begin
                    rdy_hit   = 1'b1;
                    dout_load = is_rd_reg;
                    dispatch  = 1'b1;
                end else if (wd_cnt_reg == CW'(TOUT - 1)) begin
                    // Abort: the client is released but keeps the old data.
                    rdy_hit  = 1'b1;
                    timeout  = 1'b1;
                    dispatch = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Grant decision, shared by IDLE and the completing DATA cycle so
        // that back-to-back transactions lose no cycle.
        if (dispatch) begin
            state_next = IDLE;
            if (downloading) begin
                state_next = PROG;
            end else if (pick_valid) begin
                grant      = 1'b1;
                state_next = REQ;
                owner_next = pick_idx;
                is_rd_next = ch_rd[pick_idx];
                addr_next  = addr_arr[pick_idx];
                din_next   = din_arr[pick_idx];
                mask_next  = mask_arr[pick_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            is_rd_reg     <= 1'b0;
            addr_reg      <= '0;
            din_reg       <= '0;
            mask_reg      <= '0;
            dout_reg      <= '0;
            wd_cnt_reg    <= '0;
            err_reg       <= 1'b0;
            prog_busy_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            is_rd_reg <= is_rd_next;
            addr_reg  <= addr_next;
            din_reg   <= din_next;
            mask_reg  <= mask_next;
            if (dout_load) begin
                dout_reg <= sdram_dout;
            end
            if (state_reg == REQ && ba_ack) begin
                wd_cnt_reg <= '0;
            end else if (state_reg == DATA) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (timeout) begin
                err_reg <= 1'b1;
            end
            prog_busy_reg <= (state_reg == PROG) ? prog_busy_next : 1'b0;
        end
    end

    assign ch_dout = dout_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_jtframe_bank_arb.sv
module tb_jtframe_bank_arb;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int CH = 4;

    logic             clk;
    logic             rst;
    logic             downloading;
    logic [CH*AW-1:0] ch_addr;
    logic [CH-1:0]    ch_rd;
    logic [CH-1:0]    ch_wr;
    logic [CH*DW-1:0] ch_din;
    logic [CH*2-1:0]  ch_din_m;
    logic [CH-1:0]    ch_ack;
    logic [CH-1:0]    ch_dst;
    logic [CH-1:0]    ch_dok;
    logic [CH-1:0]    ch_rdy;
    logic [DW-1:0]    ch_dout;
    logic [AW-1:0]    prog_addr;
    logic             prog_we;
    logic             prog_rd;
    logic [DW-1:0]    prog_data;
    logic [1:0]       prog_mask;
    logic             prog_ack;
    logic             prog_rdy;
    logic [AW-1:0]    ba_addr;
    logic             ba_rd;
    logic             ba_wr;
    logic [DW-1:0]    ba_din;
    logic [1:0]       ba_din_m;
    logic             ba_ack;
    logic             ba_dst;
    logic             ba_dok;
    logic             ba_rdy;
    logic [DW-1:0]    sdram_dout;
    logic             err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_dout;

    // Results of the last controller-side transaction
    int            s_acks, s_rdys, s_gap;
    logic [CH-1:0] s_ackv, s_rdyv, s_dstv, s_dokv;
    logic [AW-1:0] s_addr;
    logic          s_rd, s_wr, s_held, s_drop, s_timeout;
    logic [DW-1:0] s_din;
    logic [1:0]    s_mask;

    jtframe_bank_arb #(
        .AW(AW), .DW(DW), .CH(CH), .TOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_din(ch_din), .ch_din_m(ch_din_m),
        .ch_ack(ch_ack), .ch_dst(ch_dst), .ch_dok(ch_dok), .ch_rdy(ch_rdy), .ch_dout(ch_dout),
        .prog_addr(prog_addr), .prog_we(prog_we), .prog_rd(prog_rd), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din), .ba_din_m(ba_din_m),
        .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .sdram_dout(sdram_dout), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        downloading = 1'b0;
        ch_addr = '0; ch_rd = '0; ch_wr = '0; ch_din = '0; ch_din_m = '0;
        prog_addr = '0; prog_we = 1'b0; prog_rd = 1'b0; prog_data = '0; prog_mask = '0;
        ba_ack = 1'b0; ba_dst = 1'b0; ba_dok = 1'b0; ba_rdy = 1'b0; sdram_dout = '0;
        exp_dout = '0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    // Plays the SDRAM controller for one transaction: ack ack_dly cycles
    // after the request is seen, rdy rdy_dly cycles after it (rdy_dly < 0:
    // never). Unless hold is set, the acked client drops its request.
    task automatic serve(input int ack_dly, input int rdy_dly, input logic [DW-1:0] data,
                         input bit hold, input int budget);
        bit started = 0;
        bit done = 0;
        int t0 = 0;
        int ack_c = 0;
        s_acks = 0; s_rdys = 0; s_gap = -1;
        s_ackv = '0; s_rdyv = '0; s_dstv = '0; s_dokv = '0;
        s_addr = '0; s_rd = 0; s_wr = 0; s_din = '0; s_mask = '0;
        s_held = 1; s_drop = 1; s_timeout = 1;
        for (int c = 0; c < budget; c++) begin
            if (!started && (ba_rd || ba_wr)) begin
                started = 1; t0 = c;
                s_addr = ba_addr; s_rd = ba_rd; s_wr = ba_wr; s_din = ba_din; s_mask = ba_din_m;
            end
            if (started && c <= t0 + ack_dly && !(ba_rd || ba_wr)) s_held = 0;
            ba_ack = started && (c == t0 + ack_dly);
            ba_rdy = started && (rdy_dly >= 0) && (c == t0 + rdy_dly);
            ba_dok = ba_rdy;
            ba_dst = started && (rdy_dly >= 0) && (c == t0 + rdy_dly - 1 || c == t0 + rdy_dly);
            sdram_dout = ba_rdy ? data : 16'hDEAD;
            #1;
            if (ba_ack) begin
                ack_c = c;
                if (ba_rd || ba_wr) s_drop = 0;
            end
            s_acks += $countones(ch_ack);
            s_rdys += $countones(ch_rdy);
            s_ackv |= ch_ack;
            s_rdyv |= ch_rdy;
            s_dstv |= ch_dst;
            s_dokv |= ch_dok;
            if (ch_rdy != '0) begin
                done = 1;
                s_gap = c - ack_c;
            end
            if (!hold && ch_ack != '0) begin
                ch_rd = ch_rd & ~ch_ack;
                ch_wr = ch_wr & ~ch_ack;
            end
            tick;
            ba_ack = 0; ba_rdy = 0; ba_dok = 0; ba_dst = 0;
            if (done) begin
                s_timeout = 0;
                break;
            end
        end
        $display("txn addr=%h rd=%b wr=%b ack=%b rdy=%b dout=%h gap=%0d",
                 s_addr, s_rd, s_wr, s_ackv, s_rdyv, ch_dout, s_gap);
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (ba_rd !== 1'b0 || ba_wr !== 1'b0) begin errors++;
            $display("FAIL reset_ba_req: got rd=%b wr=%b expected 0 0", ba_rd, ba_wr); end
        checks++; if (ba_addr !== '0) begin errors++;
            $display("FAIL reset_ba_addr: got %h expected 0", ba_addr); end
        checks++; if ({ch_ack, ch_rdy, ch_dst, ch_dok} !== '0) begin errors++;
            $display("FAIL reset_ch_resp: got %h expected 0", {ch_ack, ch_rdy, ch_dst, ch_dok}); end
        checks++; if (ch_dout !== '0 || err !== 1'b0) begin errors++;
            $display("FAIL reset_dout_err: got dout=%h err=%b expected 0 0", ch_dout, err); end
        checks++; if (prog_ack !== 1'b0 || prog_rdy !== 1'b0) begin errors++;
            $display("FAIL reset_prog: got %b%b expected 00", prog_ack, prog_rdy); end
    endtask

    task automatic test_single_read;
        ch_addr[2*AW +: AW] = 22'h1234;
        ch_rd = 4'b0100;
        #1;
        checks++; if (ba_rd !== 1'b0) begin errors++;
            $display("FAIL read_latency0: got ba_rd=%b expected 0", ba_rd); end
        tick;
        checks++; if (ba_rd !== 1'b1 || ba_addr !== 22'h1234) begin errors++;
            $display("FAIL read_latency1: got rd=%b addr=%h expected 1 001234", ba_rd, ba_addr); end
        serve(3, 8, 16'hBEEF, 0, 50);
        exp_dout = 16'hBEEF;
        checks++; if (s_timeout !== 1'b0) begin errors++;
            $display("FAIL read_done: got timeout=%b expected 0", s_timeout); end
        checks++; if (s_held !== 1'b1 || s_drop !== 1'b1) begin errors++;
            $display("FAIL read_req_hold: got held=%b drop=%b expected 1 1", s_held, s_drop); end
        checks++; if (s_acks !== 1 || s_ackv !== 4'b0100) begin errors++;
            $display("FAIL read_ack: got n=%0d vec=%b expected 1 0100", s_acks, s_ackv); end
        checks++; if (s_rdys !== 1 || s_rdyv !== 4'b0100) begin errors++;
            $display("FAIL read_rdy: got n=%0d vec=%b expected 1 0100", s_rdys, s_rdyv); end
        checks++; if (s_dstv !== 4'b0100 || s_dokv !== 4'b0100) begin errors++;
            $display("FAIL read_dst_dok: got %b %b expected 0100 0100", s_dstv, s_dokv); end
        checks++; if (ch_dout !== exp_dout) begin errors++;
            $display("FAIL read_dout: got %h expected %h", ch_dout, exp_dout); end
    endtask

    task automatic test_contention;
        int own;
        logic [CH-1:0] exp_v;
        do_reset;
        for (int i = 0; i < CH; i++) ch_addr[i*AW +: AW] = AW'(22'h100 + i);
        ch_rd = 4'b1111;
        tick;
        for (int k = 0; k < 5; k++) begin
`ifdef JTFRAME_ARB_RR_EN
            own = k % CH;
`else
            own = 0;
`endif
            exp_v = 4'b0001 << own;
            serve(1, 3, DW'(16'h1000 + k), 1, 50);
            exp_dout = DW'(16'h1000 + k);
            checks++; if (s_ackv !== exp_v || s_rdyv !== exp_v) begin errors++;
                $display("FAIL contention_grant%0d: got ack=%b rdy=%b expected %b", k, s_ackv, s_rdyv, exp_v); end
            checks++; if (s_addr !== AW'(22'h100 + own)) begin errors++;
                $display("FAIL contention_addr%0d: got %h expected %h", k, s_addr, 22'h100 + own); end
        end
        // The grant made at the last rdy completes even though all clients drop.
        ch_rd = '0;
`ifdef JTFRAME_ARB_RR_EN
        exp_v = 4'b0010;
`else
        exp_v = 4'b0001;
`endif
        serve(1, 3, 16'h2000, 0, 50);
        exp_dout = 16'h2000;
        checks++; if (s_ackv !== exp_v || s_rdyv !== exp_v) begin errors++;
            $display("FAIL dropped_req: got ack=%b rdy=%b expected %b", s_ackv, s_rdyv, exp_v); end
        checks++; if (ch_dout !== exp_dout) begin errors++;
            $display("FAIL dropped_dout: got %h expected %h", ch_dout, exp_dout); end
    endtask

    task automatic test_write;
        ch_addr[1*AW +: AW] = 22'h0CAFE;
        ch_din[1*DW +: DW] = 16'hA5A5;
        ch_din_m[1*2 +: 2] = 2'b01;
        ch_wr = 4'b0010;
        tick;
        serve(2, 4, 16'h1111, 0, 50);
        checks++; if (s_wr !== 1'b1 || s_rd !== 1'b0) begin errors++;
            $display("FAIL write_dir: got wr=%b rd=%b expected 1 0", s_wr, s_rd); end
        checks++; if (s_din !== 16'hA5A5 || s_mask !== 2'b01 || s_addr !== 22'h0CAFE) begin errors++;
            $display("FAIL write_data: got din=%h m=%b a=%h expected a5a5 01 00cafe", s_din, s_mask, s_addr); end
        checks++; if (s_rdyv !== 4'b0010) begin errors++;
            $display("FAIL write_rdy: got %b expected 0010", s_rdyv); end
        checks++; if (ch_dout !== exp_dout) begin errors++;
            $display("FAIL write_dout: got %h expected %h", ch_dout, exp_dout); end
    endtask

    task automatic test_download;
        ch_addr[0*AW +: AW] = 22'h00042;
        ch_rd = 4'b0001;
        downloading = 1'b1;
        prog_addr = 22'h2ABCD; prog_we = 1'b1; prog_data = 16'h7E57; prog_mask = 2'b10;
        tick;
        checks++; if (ba_addr !== 22'h2ABCD || ba_wr !== 1'b1 || ba_din !== 16'h7E57 || ba_din_m !== 2'b10) begin
            errors++; $display("FAIL prog_pass: got a=%h wr=%b d=%h m=%b expected 2abcd 1 7e57 10",
                               ba_addr, ba_wr, ba_din, ba_din_m); end
        ba_ack = 1'b1;
        #1;
        checks++; if (prog_ack !== 1'b1 || ch_ack !== '0) begin errors++;
            $display("FAIL prog_ack: got prog=%b ch=%b expected 1 0000", prog_ack, ch_ack); end
        tick;
        ba_ack = 1'b0; prog_we = 1'b0; downloading = 1'b0; prog_addr = 22'h2ABCE;
        #1;
        checks++; if (ba_addr !== 22'h2ABCE) begin errors++;
            $display("FAIL prog_outstanding: got %h expected 2abce", ba_addr); end
        ba_rdy = 1'b1;
        #1;
        checks++; if (prog_rdy !== 1'b1 || ch_rdy !== '0) begin errors++;
            $display("FAIL prog_rdy: got prog=%b ch=%b expected 1 0000", prog_rdy, ch_rdy); end
        tick;
        ba_rdy = 1'b0;
        tick;
        serve(1, 2, 16'h4242, 0, 50);
        exp_dout = 16'h4242;
        checks++; if (s_ackv !== 4'b0001 || s_addr !== 22'h00042) begin errors++;
            $display("FAIL post_prog_grant: got ack=%b a=%h expected 0001 000042", s_ackv, s_addr); end
    endtask

    task automatic test_dl_in_data;
        ch_addr[3*AW +: AW] = 22'h3F00F;
        ch_rd = 4'b1000;
        tick;
        ba_ack = 1'b1;
        #1;
        checks++; if (ch_ack !== 4'b1000) begin errors++;
            $display("FAIL dl_data_ack: got %b expected 1000", ch_ack); end
        tick;
        ba_ack = 1'b0; ch_rd = '0;
        downloading = 1'b1; prog_addr = 22'h11111;
        #1;
        checks++; if (ba_addr !== 22'h3F00F) begin errors++;
            $display("FAIL dl_data_owner: got %h expected 3f00f", ba_addr); end
        tick;
        ba_rdy = 1'b1; sdram_dout = 16'h5A5A;
        #1;
        checks++; if (ch_rdy !== 4'b1000) begin errors++;
            $display("FAIL dl_data_rdy: got %b expected 1000", ch_rdy); end
        tick;
        ba_rdy = 1'b0;
        exp_dout = 16'h5A5A;
        #1;
        checks++; if (ba_addr !== 22'h11111 || ch_dout !== exp_dout) begin errors++;
            $display("FAIL dl_data_prog: got a=%h dout=%h expected 11111 %h", ba_addr, ch_dout, exp_dout); end
        downloading = 1'b0; prog_addr = '0;
        tick;
    endtask

    task automatic test_watchdog;
        ch_addr[1*AW +: AW] = 22'h0AAAA;
        ch_rd = 4'b0010;
        tick;
        serve(1, -1, 16'hFFFF, 0, 400);
        checks++; if (s_timeout !== 1'b0 || s_gap !== 255 || s_rdys !== 1) begin errors++;
            $display("FAIL wd_rdy: got to=%b gap=%0d n=%0d expected 0 255 1", s_timeout, s_gap, s_rdys); end
        checks++; if (s_rdyv !== 4'b0010 || err !== 1'b1) begin errors++;
            $display("FAIL wd_err: got rdy=%b err=%b expected 0010 1", s_rdyv, err); end
        checks++; if (ch_dout !== exp_dout) begin errors++;
            $display("FAIL wd_dout: got %h expected %h", ch_dout, exp_dout); end
        ch_addr[2*AW +: AW] = 22'h00777;
        ch_rd = 4'b0100;
        tick;
        serve(0, 2, 16'hC0DE, 0, 50);
        exp_dout = 16'hC0DE;
        checks++; if (s_rdyv !== 4'b0100 || ch_dout !== exp_dout || err !== 1'b1) begin errors++;
            $display("FAIL wd_after: got rdy=%b dout=%h err=%b expected 0100 %h 1", s_rdyv, ch_dout, err, exp_dout); end
    endtask

    task automatic test_async_reset;
        ch_rd = 4'b0001;
        tick;
        checks++; if (ba_rd !== 1'b1) begin errors++;
            $display("FAIL areset_pre: got ba_rd=%b expected 1", ba_rd); end
        #2;
        rst = 1'b1;
        #1;
        ba_ack = 1'b1;
        #1;
        checks++; if (ba_rd !== 1'b0 || ch_ack !== '0 || ch_rdy !== '0 || err !== 1'b0) begin errors++;
            $display("FAIL areset_mid: got rd=%b ack=%b rdy=%b err=%b expected 0 0000 0000 0",
                     ba_rd, ch_ack, ch_rdy, err); end
        ba_ack = 1'b0;
        ch_rd = '0;
        tick;
        rst = 1'b0;
        tick;
        checks++; if (ch_dout !== '0 || ba_rd !== 1'b0) begin errors++;
            $display("FAIL areset_post: got dout=%h rd=%b expected 0 0", ch_dout, ba_rd); end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_contention;
        test_write;
        test_download;
        test_dl_in_data;
        test_watchdog;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
